// File: rtl/dataload_pkg.sv
// dataload_pkg: shared types and default widths for the handshaked data loader.
package dataload_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_IN_WORDS = 8;
  localparam int DEF_WT_WORDS = 1;
  typedef enum logic {LOAD_WEIGHT = 1'b0, LOAD_INPUT = 1'b1} load_type_e;
  typedef enum logic [1:0] {CH_EMPTY, CH_FILL, CH_FULL} ch_state_e;
endpackage

// File: rtl/dataload_hs_if.sv
// dataload_hs_if: host word stream and vector handshake bundle of the data loader.
interface dataload_hs_if
  import dataload_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IN_WORDS = DEF_IN_WORDS,
  parameter int WT_WORDS = DEF_WT_WORDS
);
  logic [DATA_W-1:0]          data_i;
  logic                       load_en_i;
  load_type_e                 load_type_i;
  logic                       load_ready_o;
  logic                       flush_i;
  logic [IN_WORDS*DATA_W-1:0] input_data_o;
  logic                       input_valid_o;
  logic                       input_ack_i;
  logic [WT_WORDS*DATA_W-1:0] weight_o;
  logic                       weight_valid_o;
  logic                       weight_ack_i;
  logic                       overflow_o;
  modport master (
    output data_i, load_en_i, load_type_i, flush_i, input_ack_i, weight_ack_i,
    input  load_ready_o, input_data_o, input_valid_o, weight_o, weight_valid_o, overflow_o
  );
  modport slave (
    input  data_i, load_en_i, load_type_i, flush_i, input_ack_i, weight_ack_i,
    output load_ready_o, input_data_o, input_valid_o, weight_o, weight_valid_o, overflow_o
  );
endinterface

// File: rtl/dataload_channel.sv
// dataload_channel: packs WORDS words into one vector and holds it until acknowledged.
module dataload_channel
  import dataload_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_IN_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    wr_i,
  input  logic                    ack_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    full_o,
  output logic [WORDS*DATA_W-1:0] data_o
);
  localparam int CW = $clog2(WORDS + 1);
  ch_state_e               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WORDS*DATA_W-1:0] buf_q, buf_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (flush_i) begin
      state_d = CH_EMPTY;
      cnt_d   = '0;
      buf_d   = '0;
    end else if (state_q == CH_FULL) begin
      if (ack_i) begin
        state_d = CH_EMPTY;
        cnt_d   = '0;
      end
    end else if (wr_i) begin
      buf_d[cnt_q*DATA_W +: DATA_W] = data_i;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(WORDS - 1)) ? CH_FULL : CH_FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end
  assign full_o = (state_q == CH_FULL);
  assign data_o = buf_q;
endmodule

// File: rtl/dataload_hs.sv
// dataload_hs: steers a word stream into weight/input vector channels with backpressure.
// Define DATALOAD_HS_DBUF_EN to give the input channel two ping-pong banks.
module dataload_hs
  import dataload_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IN_WORDS = DEF_IN_WORDS,
  parameter int WT_WORDS = DEF_WT_WORDS
) (
  input logic          clk,
  input logic          rst,
  dataload_hs_if.slave bus
);
  logic wt_full, in_ready, ready, accept, in_wr, wt_wr, overflow_q, overflow_d;
  assign ready  = (bus.load_type_i == LOAD_INPUT) ? in_ready : !wt_full;
  assign accept = bus.load_en_i && ready;
  assign in_wr  = accept && (bus.load_type_i == LOAD_INPUT);
  assign wt_wr  = accept && (bus.load_type_i == LOAD_WEIGHT);
  dataload_channel #(.DATA_W(DATA_W), .WORDS(WT_WORDS)) u_wt (
    .clk, .rst, .flush_i(bus.flush_i), .wr_i(wt_wr), .ack_i(bus.weight_ack_i),
    .data_i(bus.data_i), .full_o(wt_full), .data_o(bus.weight_o)
  );
`ifdef DATALOAD_HS_DBUF_EN
  logic [1:0]                 in_full;
  logic [IN_WORDS*DATA_W-1:0] in_data [2];
  logic                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wsel;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dataload_channel #(.DATA_W(DATA_W), .WORDS(IN_WORDS)) u_in (
      .clk, .rst, .flush_i(bus.flush_i),
      .wr_i(in_wr && (wsel == 1'(b))),
      .ack_i(bus.input_ack_i && (rd_ptr_q == 1'(b))),
      .data_i(bus.data_i), .full_o(in_full[b]), .data_o(in_data[b])
    );
  end
  // Filling moves on to the other bank as soon as the current one is full.
  always_comb begin
    wsel     = in_full[wr_ptr_q] ? ~wr_ptr_q : wr_ptr_q;
    wr_ptr_d = bus.flush_i ? 1'b0 : wsel;
    rd_ptr_d = bus.flush_i ? 1'b0 : rd_ptr_q ^ (bus.input_ack_i & in_full[rd_ptr_q]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  assign in_ready          = !in_full[wsel];
  assign bus.input_valid_o = in_full[rd_ptr_q];
  assign bus.input_data_o  = in_data[rd_ptr_q];
`else
  logic in_full;
  dataload_channel #(.DATA_W(DATA_W), .WORDS(IN_WORDS)) u_in (
    .clk, .rst, .flush_i(bus.flush_i), .wr_i(in_wr), .ack_i(bus.input_ack_i),
    .data_i(bus.data_i), .full_o(in_full), .data_o(bus.input_data_o)
  );
  assign in_ready          = !in_full;
  assign bus.input_valid_o = in_full;
`endif
  assign overflow_d = bus.flush_i ? 1'b0 : overflow_q | (bus.load_en_i & !ready);
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end
  assign bus.load_ready_o   = ready;
  assign bus.weight_valid_o = wt_full;
  assign bus.overflow_o     = overflow_q;
endmodule

// File: tb/tb_dataload_hs.sv
// tb_dataload_hs: directed self-checking bench for dataload_hs.
module tb_dataload_hs;
  import dataload_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  logic [255:0] exp_in;
  dataload_hs_if #(.DATA_W(32), .IN_WORDS(8), .WT_WORDS(1)) bus ();
  dataload_hs #(.DATA_W(32), .IN_WORDS(8), .WT_WORDS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input load_type_e t, input logic [31:0] d);
    bus.load_en_i   = 1'b1;
    bus.load_type_i = t;
    bus.data_i      = d;
    step();
    bus.load_en_i   = 1'b0;
  endtask
  initial begin
    bus.data_i = '0; bus.load_en_i = 1'b0; bus.load_type_i = LOAD_INPUT;
    bus.flush_i = 1'b0; bus.input_ack_i = 1'b0; bus.weight_ack_i = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_in_valid", 256'(bus.input_valid_o), 256'd0);
    check("rst_wt_valid", 256'(bus.weight_valid_o), 256'd0);
    check("rst_in_data", bus.input_data_o, 256'd0);
    check("rst_wt_data", 256'(bus.weight_o), 256'd0);
    check("rst_overflow", 256'(bus.overflow_o), 256'd0);
    check("rst_ready", 256'(bus.load_ready_o), 256'd1);
    exp_in = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("in_valid_before_last", 256'(bus.input_valid_o), 256'd0);
      put(LOAD_INPUT, 32'(i + 1));
      exp_in[i*32 +: 32] = 32'(i + 1);
    end
    check("in_valid_8", 256'(bus.input_valid_o), 256'd1);
    check("in_data_8", bus.input_data_o, exp_in);
    put(LOAD_WEIGHT, 32'hDEADBEEF);
    check("wt_valid", 256'(bus.weight_valid_o), 256'd1);
    check("wt_data", 256'(bus.weight_o), 256'hDEADBEEF);
    check("in_valid_kept", 256'(bus.input_valid_o), 256'd1);
    check("in_data_kept", bus.input_data_o, exp_in);
`ifndef DATALOAD_HS_DBUF_EN
    bus.load_en_i = 1'b1; bus.load_type_i = LOAD_INPUT; bus.data_i = 32'h55;
    #1 check("drop_ready", 256'(bus.load_ready_o), 256'd0);
    step();
    bus.load_en_i = 1'b0;
    check("drop_overflow", 256'(bus.overflow_o), 256'd1);
    check("drop_data", bus.input_data_o, exp_in);
    bus.load_en_i = 1'b1; bus.data_i = 32'h66; bus.input_ack_i = 1'b1;
    #1 check("ackwr_ready", 256'(bus.load_ready_o), 256'd0);
    step();
    bus.load_en_i = 1'b0; bus.input_ack_i = 1'b0;
    check("ackwr_valid", 256'(bus.input_valid_o), 256'd0);
    check("ackwr_ready_back", 256'(bus.load_ready_o), 256'd1);
    check("ackwr_data", bus.input_data_o, exp_in);
`endif
    bus.weight_ack_i = 1'b1;
    step();
    bus.weight_ack_i = 1'b0;
    check("wt_ack_valid", 256'(bus.weight_valid_o), 256'd0);
    put(LOAD_INPUT, 32'hA);
    put(LOAD_INPUT, 32'hB);
    put(LOAD_INPUT, 32'hC);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_valid", 256'(bus.input_valid_o), 256'd0);
    check("flush_data", bus.input_data_o, 256'd0);
    check("flush_overflow", 256'(bus.overflow_o), 256'd0);
    exp_in = '0;
    for (int i = 0; i < 8; i++) begin
      put(LOAD_INPUT, 32'h10 + 32'(i));
      exp_in[i*32 +: 32] = 32'h10 + 32'(i);
    end
    check("reload_valid", 256'(bus.input_valid_o), 256'd1);
    check("reload_data", bus.input_data_o, exp_in);
    bus.input_ack_i = 1'b1;
    step();
    bus.input_ack_i = 1'b0;
    check("reload_ack_valid", 256'(bus.input_valid_o), 256'd0);
`ifdef DATALOAD_HS_DBUF_EN
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    exp_in = '0;
    for (int i = 0; i < 16; i++) begin
      bus.load_type_i = LOAD_INPUT;
      #1 check("dbuf_ready", 256'(bus.load_ready_o), 256'd1);
      put(LOAD_INPUT, 32'(i + 1));
      if (i < 8) exp_in[i*32 +: 32] = 32'(i + 1);
    end
    check("dbuf_ready_full", 256'(bus.load_ready_o), 256'd0);
    check("dbuf_valid", 256'(bus.input_valid_o), 256'd1);
    check("dbuf_data0", bus.input_data_o, exp_in);
    bus.input_ack_i = 1'b1;
    step();
    bus.input_ack_i = 1'b0;
    for (int i = 0; i < 8; i++) exp_in[i*32 +: 32] = 32'(i + 9);
    check("dbuf_valid_ack", 256'(bus.input_valid_o), 256'd1);
    check("dbuf_data1", bus.input_data_o, exp_in);
    check("dbuf_ready_ack", 256'(bus.load_ready_o), 256'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dataload_hs.md
# dataload_hs

Parametrised, handshaked successor to the weight/input loader. It accepts a serial word stream and steers each word to a weight channel or an input channel by `load_type_i`. Each channel packs words into a wide vector, holds the vector until the downstream consumer acknowledges it, and applies backpressure instead of overwriting. The block sits between the host word interface and the first-level compute array, feeding the array's input vector and weight operand.

## Interface
- `DATA_W`, 32: word width in bits.
- `IN_WORDS`, 8: words per input vector (≥1).
- `WT_WORDS`, 1: words per weight vector (≥1).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `data_i` in DATA_W: load word.
- `load_en_i` in 1: word valid.
- `load_type_i` in 1: destination; 0 = weight, 1 = input.
- `load_ready_o` out 1: selected destination can accept `data_i` this cycle.
- `flush_i` in 1: synchronous clear of both channels and `overflow_o`.
- `input_data_o` out IN_WORDS*DATA_W: packed input vector.
- `input_valid_o` out 1: input vector complete and stable.
- `input_ack_i` in 1: consumer takes the input vector.
- `weight_o` out WT_WORDS*DATA_W: packed weight vector.
- `weight_valid_o` out 1: weight vector complete and stable.
- `weight_ack_i` in 1: consumer takes the weight vector.
- `overflow_o` out 1: sticky; a word was offered (`load_en_i`=1) while `load_ready_o`=0.

## Operation
- Word accept: `load_en_i && load_ready_o`. The word goes to the channel selected by `load_type_i`. The other channel is untouched.
- Packing: word k of a vector (k = 0..N-1, in arrival order) lands in bits [k*DATA_W +: DATA_W]. Word 0 is the LSBs.
- Per-channel FSM:
  - EMPTY → FILL on the first accepted word (or directly to FULL when N=1).
  - FILL → FULL when the accepted word brings the count to N.
  - FULL → EMPTY on `ack` while valid.
- Fill counter width is `$clog2(N+1)`. The counter resets to 0 on every transition into EMPTY.
- `valid_o` = (state == FULL). Data outputs are stable for the whole time valid is high. Unfilled slots read 0 after reset or flush.
- `load_ready_o` is combinational from `load_type_i` and the selected channel's state. It is 1 unless the selected channel is FULL (single-buffer case).
- Dropped word (`load_en_i`=1, `load_ready_o`=0): no state change, and `overflow_o` sets from the next cycle.
- `ack` while not valid is ignored.
- `load_en_i`=0 means the other inputs are don't-care.
- Flush or reset in mid-fill discards the partial vector: state EMPTY, count 0, data cleared.

## Timing
- Reset values: `input_valid_o`=0, `weight_valid_o`=0, `input_data_o`=0, `weight_o`=0, `overflow_o`=0, `load_ready_o`=1.
- Latency: valid rises the cycle after the N-th word is accepted.
- Ack: valid falls the cycle after `ack`. `load_ready_o` for that channel returns the same cycle that valid falls.
- Ack and an offered write to the same FULL channel in the same cycle: the write is refused, since ready reflects the current state, and `overflow_o` sets.
- An ack on one channel and a write to the other channel in the same cycle proceed independently.
- `flush_i` has priority over everything except `rst`. `rst` has top priority.

## Configuration
- Macro `DATALOAD_HS_DBUF_EN` defined: the input channel gets two banks (ping-pong).
  - Filling continues into the free bank while the other bank is FULL and presented.
  - `load_ready_o` for input drops only when both banks are FULL.
  - The oldest full bank is presented first.
  - On ack with the other bank FULL, `input_valid_o` stays 1 and `input_data_o` switches to the other bank the next cycle.
  - The weight channel stays single-buffered.
- Macro undefined: both channels are single-buffered, exactly as described under Operation.

## Structure
- `dataload_pkg` holds:
  - enum `load_type_e` (`LOAD_WEIGHT`=0, `LOAD_INPUT`=1);
  - channel state enum (`CH_EMPTY`, `CH_FILL`, `CH_FULL`);
  - default width constants.
- Sub-module `dataload_channel`, parametrised on `DATA_W` and `WORDS`, implements the FSM, the counter and the packing register.
  - It is instantiated once for weight and once for input.
  - It is instantiated twice for input under `DATALOAD_HS_DBUF_EN`, with a bank-select pointer in the top level.
- The top level holds the steering logic, the ready mux and the overflow flag.

## Test plan
- Reset, then load 8 input words 0x1..0x8 → `input_valid_o`=1 one cycle after the 8th word; `input_data_o`=0x00000008_..._00000001.
- Load weight 0xDEADBEEF (WT_WORDS=1) → `weight_valid_o`=1 next cycle and `weight_o`=0xDEADBEEF; input channel state unchanged.
- With input FULL, offer word 0x55 as input → `load_ready_o`=0, word dropped, `overflow_o`=1 next cycle; `input_data_o` unchanged.
- Same cycle: `input_ack_i`=1 and an input write offered → write refused; valid falls next cycle; ready=1 from that cycle.
- Load 3 input words, then `flush_i` → state EMPTY and `input_data_o`=0; a following 8-word load packs from slot 0.
- `DATALOAD_HS_DBUF_EN`: load 16 words with no ack → ready stays 1 until the 16th word. Ack once → valid stays 1 and the data switches to words 9..16.
